// File: rtl/dvp_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : dvp_tx_if                                                |
// | Brief   : DVP byte bus plus optional external RGB565 pixel input   |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
interface dvp_tx_if;
  logic [15:0] I_pix_data;
  logic        I_pix_valid;
  logic        O_pix_ready;
  logic        O_vsync;
  logic        O_href;
  logic [7:0]  O_data;

  modport master (
    input  I_pix_data, I_pix_valid,
    output O_pix_ready, O_vsync, O_href, O_data
  );

  modport slave (
    output I_pix_data, I_pix_valid,
    input  O_pix_ready, O_vsync, O_href, O_data
  );
endinterface
`default_nettype wire

// File: rtl/dvp_tx_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : dvp_tx_emulator                                          |
// | Brief   : OV5640-style DVP source emitting RGB565 (high byte       |
// |           first); colour bars, or external pixels when the macro   |
// |           DVP_TX_PIXEL_IN_EN is defined                            |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
module dvp_tx_emulator #(
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 8
) (
  input  logic     cmos_pclk,
  input  logic     I_rst_n,
  input  logic     I_en,
  dvp_tx_if.master dvp,
  output logic     O_frame_start,
  output logic     O_frame_done,
  output logic     O_underrun
);

  localparam int c_LINE      = 2 * H_ACT + H_BLANK;
  localparam int c_LINES     = VS_LINES + V_BACK + V_ACT + V_FRONT;
  localparam int c_CW        = (c_LINE > 1) ? $clog2(c_LINE) : 1;
  localparam int c_LW        = (c_LINES > 1) ? $clog2(c_LINES) : 1;
  localparam int c_ACT_FIRST = VS_LINES + V_BACK;
  localparam int c_ACT_END   = c_ACT_FIRST + V_ACT;
  localparam int c_BYTES     = 2 * H_ACT;

  localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(c_LINE - 1);
  localparam logic [c_LW-1:0] c_LINE_LAST = c_LW'(c_LINES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFRONT = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [c_LW-1:0] r_line;
  logic [c_LW-1:0] w_line_nxt;
  logic [c_CW-1:0] r_col;
  logic [c_CW-1:0] w_col_nxt;
  logic            w_start;
  logic            w_frame_end;
  logic            w_done_nxt;
  logic [15:0]     w_pix;
  logic [15:0]     r_pix;

  // Position within the frame decides the in-frame state; zero-length regions fall through.
  function automatic logic [2:0] f_decode(input logic [c_LW-1:0] ln, input logic [c_CW-1:0] col);
    logic [2:0] st;
    if (int'(ln) < VS_LINES)
      st = S_VSYNC;
    else if (int'(ln) < c_ACT_FIRST)
      st = S_VBACK;
    else if (int'(ln) < c_ACT_END)
      st = (int'(col) < c_BYTES) ? S_ACTIVE : S_HBLANK;
    else
      st = S_VFRONT;
    return st;
  endfunction

  function automatic logic [c_LW+c_CW-1:0] f_adv(input logic [c_LW-1:0] ln, input logic [c_CW-1:0] col);
    logic [c_LW+c_CW-1:0] pos;
    if (col != c_COL_LAST)
      pos = {ln, col + c_CW'(1)};
    else if (ln != c_LINE_LAST)
      pos = {ln + c_LW'(1), {c_CW{1'b0}}};
    else
      pos = '0;
    return pos;
  endfunction

  assign w_frame_end = (r_line == c_LINE_LAST) && (r_col == c_COL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_col_nxt   = r_col;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (I_en) begin
          w_line_nxt  = '0;
          w_col_nxt   = '0;
          w_state_nxt = f_decode('0, '0);
          w_start     = 1'b1;
        end
      end
      default: begin
        if (w_frame_end) begin
          w_line_nxt = '0;
          w_col_nxt  = '0;
          if (I_en) begin
            w_state_nxt = f_decode('0, '0);
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          {w_line_nxt, w_col_nxt} = f_adv(r_line, r_col);
          w_state_nxt = f_decode(w_line_nxt, w_col_nxt);
        end
      end
    endcase
  end

  assign w_done_nxt = (w_state_nxt != S_IDLE) && (w_line_nxt == c_LINE_LAST) &&
                      (w_col_nxt == c_COL_LAST);

  // Outputs are registered from the next position so they line up with the state register.
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state       <= S_IDLE;
      r_line        <= '0;
      r_col         <= '0;
      r_pix         <= '0;
      dvp.O_vsync   <= 1'b0;
      dvp.O_href    <= 1'b0;
      dvp.O_data    <= '0;
      O_frame_start <= 1'b0;
      O_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_line        <= w_line_nxt;
      r_col         <= w_col_nxt;
      dvp.O_vsync   <= (w_state_nxt == S_VSYNC);
      dvp.O_href    <= (w_state_nxt == S_ACTIVE);
      O_frame_start <= w_start;
      O_frame_done  <= w_done_nxt;
      if (w_state_nxt == S_ACTIVE) begin
        if (!w_col_nxt[0]) begin
          r_pix      <= w_pix;
          dvp.O_data <= w_pix[15:8];
        end else begin
          dvp.O_data <= r_pix[7:0];
        end
      end else begin
        dvp.O_data <= '0;
      end
    end
  end

`ifdef DVP_TX_PIXEL_IN_EN
  logic [c_LW-1:0] w_line_nx2;
  logic [c_CW-1:0] w_col_nx2;
  logic            w_ready_nxt;

  // Ready is raised one cycle ahead of each high byte so the word is in hand at phase 0.
  always_comb begin
    {w_line_nx2, w_col_nx2} = f_adv(w_line_nxt, w_col_nxt);
    w_ready_nxt = (w_state_nxt != S_IDLE) &&
                  (f_decode(w_line_nx2, w_col_nx2) == S_ACTIVE) && !w_col_nx2[0];
  end

  assign w_pix = (dvp.O_pix_ready && dvp.I_pix_valid) ? dvp.I_pix_data : 16'h0000;

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      dvp.O_pix_ready <= 1'b0;
      O_underrun      <= 1'b0;
    end else begin
      dvp.O_pix_ready <= w_ready_nxt;
      O_underrun      <= (dvp.O_pix_ready && !dvp.I_pix_valid) ||
                         (O_underrun && !O_frame_start);
    end
  end
`else
  localparam int c_BAR_W = H_ACT / 8;

  logic [2:0] w_bar;
  logic       w_unused_pix;

  assign w_bar        = 3'((int'(w_col_nxt) / 2) / c_BAR_W);
  assign w_unused_pix = ^{dvp.I_pix_data, dvp.I_pix_valid};

  always_comb begin
    case (w_bar)
      3'd0:    w_pix = 16'hFFFF;
      3'd1:    w_pix = 16'hFFE0;
      3'd2:    w_pix = 16'h07FF;
      3'd3:    w_pix = 16'h07E0;
      3'd4:    w_pix = 16'hF81F;
      3'd5:    w_pix = 16'hF800;
      3'd6:    w_pix = 16'h001F;
      default: w_pix = 16'h0000;
    endcase
  end

  assign dvp.O_pix_ready = 1'b0;
  assign O_underrun      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvp_tx_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_dvp_tx_emulator                                       |
// | Brief   : directed bench for dvp_tx_emulator with byte scoreboard  |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dvp_tx_emulator;

  localparam int H_ACT    = 16;
  localparam int V_ACT    = 4;
  localparam int H_BLANK  = 8;
  localparam int VS_LINES = 1;
  localparam int V_BACK   = 1;
  localparam int V_FRONT  = 1;
  localparam int LINE     = 40;
  localparam int FRAME    = 280;
`ifdef DVP_TX_PIXEL_IN_EN
  localparam bit PIX_IN = 1'b1;
`else
  localparam bit PIX_IN = 1'b0;
`endif

  logic cmos_pclk = 1'b0;
  logic I_rst_n   = 1'b0;
  logic I_en      = 1'b0;
  logic O_frame_start;
  logic O_frame_done;
  logic O_underrun;

  dvp_tx_if dvp();

  dvp_tx_emulator #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK),
    .VS_LINES(VS_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .cmos_pclk    (cmos_pclk),
    .I_rst_n      (I_rst_n),
    .I_en         (I_en),
    .dvp          (dvp),
    .O_frame_start(O_frame_start),
    .O_frame_done (O_frame_done),
    .O_underrun   (O_underrun)
  );

  always #5 cmos_pclk = ~cmos_pclk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb_q[$];
  logic [15:0] bars[8];
  bit          drop_frame = 1'b0;
  bit          ur_frame   = 1'b0;
  int          ready_cnt  = 0;

  // Pixel 5 of a flagged frame sees valid low during its ready cycle.
  always @(posedge cmos_pclk) begin
    if (O_frame_start)
      ready_cnt <= 0;
    else if (dvp.O_pix_ready)
      ready_cnt <= ready_cnt + 1;
  end
  assign dvp.I_pix_valid = !(drop_frame && dvp.O_pix_ready && (ready_cnt == 5));

  always @(negedge cmos_pclk) begin
    if (I_rst_n && dvp.O_href) begin
      checks++;
      assert (sb_q.size() != 0)
      else begin
        errors++;
        $error("FAIL sb_underflow: observed byte %02h, expected no byte", dvp.O_data);
      end
      if (sb_q.size() != 0) begin
        automatic logic [7:0] exp_b = sb_q.pop_front();
        checks++;
        assert (dvp.O_data === exp_b)
        else begin
          errors++;
          $error("FAIL sb_byte: observed %02h expected %02h", dvp.O_data, exp_b);
        end
      end
    end
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic bit act_even(input int t);
    int ln = t / LINE;
    int col = t % LINE;
    return (ln >= 2) && (ln < 6) && (col < 32) && (col % 2 == 0);
  endfunction

  task automatic push_frame(input bit drop5);
    for (int ln = 0; ln < V_ACT; ln++) begin
      for (int p = 0; p < H_ACT; p++) begin
        logic [15:0] w;
        if (PIX_IN)
          w = (drop5 && ln == 0 && p == 5) ? 16'h0000 : 16'h1234;
        else
          w = bars[p / 2];
        sb_q.push_back(w[15:8]);
        sb_q.push_back(w[7:0]);
      end
    end
  endtask

  task automatic run_frame(input int drop_en_at, input int abort_at);
    push_frame(drop_frame);
    for (int t = 0; t < FRAME; t++) begin
      int  ln;
      int  col;
      bit  exp_hr;
      @(negedge cmos_pclk);
      ln     = t / LINE;
      col    = t % LINE;
      exp_hr = (ln >= 2) && (ln < 6) && (col < 32);
      chk("vsync", t, 32'(dvp.O_vsync), 32'(ln < 1));
      chk("href", t, 32'(dvp.O_href), 32'(exp_hr));
      chk("frame_start", t, 32'(O_frame_start), 32'(t == 0));
      chk("frame_done", t, 32'(O_frame_done), 32'(t == FRAME - 1));
      chk("pix_ready", t, 32'(dvp.O_pix_ready), 32'(PIX_IN && act_even(t + 1)));
      if (!exp_hr)
        chk("blank_data", t, 32'(dvp.O_data), 32'h0);
      if (t == 20)
        chk("underrun_cleared", t, 32'(O_underrun), 32'h0);
      if (t == 200)
        chk("underrun_mid", t, 32'(O_underrun), 32'(PIX_IN && ur_frame));
      if (t == drop_en_at)
        I_en = 1'b0;
      if (t == abort_at)
        return;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cmos_pclk);
      chk("idle_vsync", i, 32'(dvp.O_vsync), 32'h0);
      chk("idle_href", i, 32'(dvp.O_href), 32'h0);
      chk("idle_data", i, 32'(dvp.O_data), 32'h0);
      chk("idle_start", i, 32'(O_frame_start), 32'h0);
    end
  endtask

  initial begin
    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
    dvp.I_pix_data = 16'h1234;

    repeat (3) @(negedge cmos_pclk);
    chk("rst_vsync", 0, 32'(dvp.O_vsync), 32'h0);
    chk("rst_href", 0, 32'(dvp.O_href), 32'h0);
    chk("rst_data", 0, 32'(dvp.O_data), 32'h0);
    chk("rst_start", 0, 32'(O_frame_start), 32'h0);
    chk("rst_done", 0, 32'(O_frame_done), 32'h0);
    chk("rst_underrun", 0, 32'(O_underrun), 32'h0);
    chk("rst_ready", 0, 32'(dvp.O_pix_ready), 32'h0);

    I_rst_n = 1'b1;
    idle_check(5);

    // Two back-to-back frames; the first drops pixel 5 in the external-pixel build.
    I_en       = 1'b1;
    drop_frame = 1'b1;
    ur_frame   = 1'b1;
    run_frame(-1, -1);
    drop_frame = 1'b0;
    ur_frame   = 1'b0;
    run_frame(-1, -1);

    // Enable dropped during line 2 still finishes the frame.
    run_frame(90, -1);
    idle_check(30);
    chk("sb_drained", 0, 32'(sb_q.size()), 32'h0);

    // Reset mid-href clears the outputs with no clock edge.
    I_en = 1'b1;
    run_frame(-1, 85);
    #2;
    I_rst_n = 1'b0;
    #1;
    chk("arst_href", 0, 32'(dvp.O_href), 32'h0);
    chk("arst_vsync", 0, 32'(dvp.O_vsync), 32'h0);
    chk("arst_data", 0, 32'(dvp.O_data), 32'h0);
    sb_q.delete();
    I_en = 1'b0;
    @(negedge cmos_pclk);
    @(negedge cmos_pclk);
    I_rst_n = 1'b1;
    idle_check(10);

    // A fresh frame starts from vsync after reset.
    I_en = 1'b1;
    run_frame(0, -1);
    idle_check(5);
    chk("sb_final", 0, 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
